// File: rtl/instr_sequencer_pkg.sv
// Shared types for the lab CPU sequencer: ISA opcodes, FSM states and
// instruction field positions.
package cpu_pkg;

  localparam int INSTR_WIDTH = 6;

  localparam int OPC_MSB = 5;
  localparam int OPC_LSB = 4;
  localparam int DST_MSB = 3;
  localparam int DST_LSB = 2;
  localparam int TGT_MSB = 3;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_ALU  = 2'b01,
    OP_JMP  = 2'b10,
    OP_HALT = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK,
    HALTED,
    ERROR
  } state_e;

  function automatic opcode_e get_opcode(input logic [INSTR_WIDTH-1:0] ins);
    return opcode_e'(ins[OPC_MSB:OPC_LSB]);
  endfunction

  function automatic logic [1:0] get_dst(input logic [INSTR_WIDTH-1:0] ins);
    return ins[DST_MSB:DST_LSB];
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Program-memory fetch bus: request/address out, ack/data back.
interface instr_sequencer_if import cpu_pkg::*; #(
  parameter int PC_WIDTH = 8
);
  logic                   mem_req;
  logic [PC_WIDTH-1:0]    mem_addr;
  logic                   mem_ack;
  logic [INSTR_WIDTH-1:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/instr_sequencer_timeout.sv
// Counts FETCH cycles without an ack; expired flags the last allowed cycle.
module fetch_timeout_counter #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // expired is asserted during the LIMIT-th consecutive counted cycle
  assign expired = (cnt_q >= W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && !expired)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller for the lab CPU: fetches instructions,
// holds the instruction register and issues ALU and register-write strobes.
//
//   state     | meaning
//   IDLE      | after reset, waiting for start
//   FETCH     | mem_req high at pc, waiting for ack (timed out -> ERROR)
//   DECODE    | instruction register valid, choose next step
//   EXECUTE   | ALU strobe, or load jump target into pc
//   WRITEBACK | one-hot register clock enable, pc+1
//   HALTED    | HALT executed, outputs frozen until start
//   ERROR     | fetch timed out, outputs frozen until start
module instr_sequencer import cpu_pkg::*; #(
  parameter int PC_WIDTH    = 8,
  parameter int NUM_REGS    = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  instr_sequencer_if.master      mem,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   alu_en,
  output logic [NUM_REGS-1:0]    ce_reg,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   busy,
  output logic                   halted,
  output logic                   err
);
  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   mem_req_q, mem_req_d;
  logic                   alu_en_q, alu_en_d;
  logic [NUM_REGS-1:0]    ce_reg_q, ce_reg_d;
  logic                   busy_q, busy_d;
  logic                   halted_q, halted_d;
  logic                   err_q, err_d;
  logic                   tmo_expired;

  fetch_timeout_counter #(.LIMIT(MEM_TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     ((state_q != FETCH) || mem.mem_ack),
    .en      (state_q == FETCH),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      IDLE, HALTED, ERROR: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = '0;
        end
      end
      FETCH: begin
        if (mem.mem_ack) begin
          instr_d = mem.mem_rdata;
          state_d = DECODE;
        end else if (tmo_expired) begin
          state_d = ERROR;
        end
      end
      DECODE: begin
        case (get_opcode(instr_q))
          OP_NOP: begin
            pc_d    = pc_q + 1'b1;
            state_d = FETCH;
          end
          OP_HALT: state_d = HALTED;
          default: state_d = EXECUTE;
        endcase
      end
      EXECUTE: begin
        if (get_opcode(instr_q) == OP_JMP) begin
          pc_d    = PC_WIDTH'(instr_q[TGT_MSB:0]);
          state_d = FETCH;
        end else begin
          state_d = WRITEBACK;
        end
      end
      WRITEBACK: begin
        pc_d    = pc_q + 1'b1;
        state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered with it
  always_comb begin
    mem_req_d = (state_d == FETCH);
    alu_en_d  = (state_d == EXECUTE) && (get_opcode(instr_d) == OP_ALU);
    ce_reg_d  = '0;
    if (state_d == WRITEBACK)
      ce_reg_d[get_dst(instr_d)] = 1'b1;
    busy_d    = (state_d == FETCH) || (state_d == DECODE) ||
                (state_d == EXECUTE) || (state_d == WRITEBACK);
    halted_d  = (state_d == HALTED);
    err_d     = (state_d == ERROR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      mem_req_q <= 1'b0;
      alu_en_q  <= 1'b0;
      ce_reg_q  <= '0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      mem_req_q <= mem_req_d;
      alu_en_q  <= alu_en_d;
      ce_reg_q  <= ce_reg_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
      err_q     <= err_d;
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = pc_q;
  assign instr        = instr_q;
  assign alu_en       = alu_en_q;
  assign ce_reg       = ce_reg_q;
  assign pc           = pc_q;
  assign busy         = busy_q;
  assign halted       = halted_q;
  assign err          = err_q;
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle fetch/decode/execute controller for the lab CPU datapath. It fetches 6-bit instructions from program memory over a req/ack handshake and holds the current one in an instruction register that feeds instruction_decoder. It sequences the datapath through FSM states and produces the ALU enable strobe and per-register clock-enable strobes (ce_reg) at the correct cycle. It sits between program memory, instruction_decoder and the register file/ALU.

Parameters:
PC_WIDTH, 8, program counter / memory address width
INSTR_WIDTH, 6, instruction width; fixed at 6 by the ISA
NUM_REGS, 4, number of general registers; addressed by 2-bit fields
MEM_TIMEOUT, 15, maximum cycles in FETCH without mem_ack before ERROR

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; starts execution from PC 0 (honoured in IDLE, HALTED, ERROR only)
mem_req  out  1  fetch request, held until ack
mem_addr  out  PC_WIDTH  fetch address (= pc)
mem_ack  in  1  memory returns data this cycle; sampled only while mem_req=1
mem_rdata  in  INSTR_WIDTH  instruction data, valid with mem_ack
instr  out  INSTR_WIDTH  instruction register contents, to instruction_decoder
alu_en  out  1  one-cycle ALU execute strobe
ce_reg  out  NUM_REGS  one-hot register write-enable strobe
pc  out  PC_WIDTH  current program counter
busy  out  1  high in FETCH/DECODE/EXECUTE/WRITEBACK
halted  out  1  high in HALTED
err  out  1  high in ERROR

Behaviour:
- Reset (async, immediate, any state incl. mid-fetch): state=IDLE, pc=0, instr=0, mem_req=0, mem_addr=0, alu_en=0, ce_reg=0, busy=0, halted=0, err=0, timeout counter=0.
- ISA: instr[5:4] opcode; 00 NOP, 01 ALU (dst=instr[3:2], src=instr[1:0]), 10 JMP (target = instr[3:0] zero-extended to PC_WIDTH), 11 HALT (operand bits ignored).
- IDLE: start -> FETCH with pc=0.
- FETCH: mem_req=1, mem_addr=pc, counter increments each cycle. mem_ack in the same cycle as mem_req is legal: capture mem_rdata into instr, clear counter, -> DECODE. Counter reaching MEM_TIMEOUT without ack -> ERROR, mem_req drops next cycle.
- DECODE (1 cycle): NOP -> FETCH with pc+1; HALT -> HALTED with pc unchanged; ALU/JMP -> EXECUTE.
- EXECUTE (1 cycle): ALU: alu_en=1 -> WRITEBACK. JMP: pc<=target -> FETCH.
- WRITEBACK (1 cycle): ce_reg = one-hot(dst), pc<=pc+1 -> FETCH.
- HALTED / ERROR: hold pc and instr; outputs static; start -> FETCH with pc=0, instr retained until next capture, err/halted cleared.
- Strobes are registered FSM outputs: alu_en high exactly in EXECUTE of an ALU op; ce_reg nonzero exactly in WRITEBACK; never both in the same cycle.
- pc+1 wraps modulo 2^PC_WIDTH (0xFF -> 0x00), no flag.
- start while busy is ignored. mem_ack outside FETCH is ignored.
- Latency with zero-wait memory: NOP 2 cycles, HALT 2, JMP 3, ALU 4 (FETCH to next FETCH). Each wait cycle adds one.
- instr is updated only on an accepted ack; it stays stable for the whole instruction for the combinational decoder.

Decomposition:
- Package cpu_pkg: opcode enum (OP_NOP, OP_ALU, OP_JMP, OP_HALT), FSM state enum (IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED, ERROR), instruction field index constants, INSTR_WIDTH.
- One natural sub-module, fetch_timeout_counter: counter with clear/enable and an expired flag. The FSM, pc and instr register stay in instr_sequencer.

Test Plan:
- Reset mid-FETCH (mem_req=1), drop rst_n -> mem_req, busy, pc, instr = 0 in the same cycle; state IDLE after release.
- Zero-wait program [0x00 NOP, 0x1B ALU dst=2 src=3, 0x3C HALT], start -> alu_en pulses once, ce_reg=4'b0100 exactly one cycle later, halted=1 with pc=2; 8 cycles from first mem_req to halted.
- JMP 0x25 (target 5) at pc=0 -> next mem_addr=5; 0x3F at addr 5 -> halted, pc=5.
- Memory ack delayed 3 cycles -> mem_req and mem_addr held stable for 4 cycles; instr captured only on the ack cycle; no timeout.
- No ack for MEM_TIMEOUT cycles -> err=1, mem_req=0, busy=0; start -> err=0, fetch resumes at addr 0.
- pc=0xFF holding a NOP -> next fetch at 0x00; start pulsed while busy has no effect on pc.
